bcd_display_formatter: RTL
==========================

// Module: bcd_display_formatter
// PURPOSE
//  Sequential signed-binary to BCD converter (double-dabble, 1 bit/clk) feeding the per-digit
//  seven-segment decoders. Converts RPN stack-top VALUE into DIGITS nibbles plus blank/minus
//  masks and an overflow flag. Sits between the calculator datapath and the HEX digit decoders.
// PARAMETERS
//  WIDTH   16  bit width of signed input VALUE (legal range 4..32)
//  DIGITS  6   number of display digits driven (legal range 2..8)
// PORTS
//  CLK    in   1           system clock, rising edge
//  RST_N  in   1           asynchronous active-low reset
//  START  in   1           request conversion of VALUE (sampled only in IDLE)
//  VALUE  in   WIDTH       two's-complement operand
//  BUSY   out  1           high while a conversion is in progress
//  DONE   out  1           one-cycle pulse when outputs are updated
//  BCD    out  4*DIGITS    digit nibbles, digit 0 = LS nibble [3:0]
//  BLANK  out  DIGITS      1 = digit shows no numeral (decoder output OFF unless MINUS)
//  MINUS  out  DIGITS      one-hot (or zero) position of '-' sign; that position also has BLANK=1
//  ERR    out  1           result does not fit on DIGITS positions
// BEHAVIOUR
//  - Reset (async): state IDLE; BUSY=0, DONE=0, BCD=0, BLANK={DIGITS-1{1},0} (shows "0"), MINUS=0, ERR=0.
//  - States: IDLE -> SHIFT (on START) -> FINISH -> IDLE.
//  - IDLE: START=1 latches sign=VALUE[WIDTH-1], mag=|VALUE| as WIDTH-bit unsigned (min value
//    -2^(WIDTH-1) -> mag 2^(WIDTH-1), no overflow); clears internal BCD; count=WIDTH-1.
//  - SHIFT: each cycle add-3 every internal digit >=5, then shift {bcd,mag} left 1; count--.
//    Leaves after WIDTH shift cycles. BUSY=1 in SHIFT and FINISH.
//  - FINISH: compute outputs, register them, DONE=1 for this one cycle, return to IDLE.
//  - Latency: START sampled at edge N -> DONE high in cycle N+WIDTH+1; next START accepted the
//    cycle after DONE. START while BUSY ignored (no queueing). Outputs hold until next FINISH.
//  - Internal digit count NI = (WIDTH*3)/10+1; digits >= DIGITS examined only for overflow.
//  - Significant digits S = index of MS nonzero digit + 1 (S=1 for value 0).
//  - ERR=1 if S>DIGITS, or sign=1 and S>DIGITS-1. On ERR: BCD=0, BLANK=all 1, MINUS=0.
//  - Else: BLANK[i]=1 for i>=S; digit 0 never blanked; if sign, MINUS[S]=1 (BLANK[S] stays 1).
//  - -0 impossible (two's complement); value 0 gives MINUS=0.
//  - Reset mid-conversion aborts immediately; no DONE issued; outputs return to reset values.
// CONFIGURATION
//  - HEX_MODE_EN defined: adds input HEX_MODE (1 bit). START with HEX_MODE=1 bypasses
//    conversion: IDLE -> FINISH directly (DONE one cycle after START); BCD = VALUE zero-extended
//    nibbles (raw, not negated), MINUS=0, leading-zero blanking as above, ERR if VALUE needs more
//    than DIGITS nibbles. Digits A-F allowed only in this mode.
//  - Not defined: no HEX_MODE port; decimal conversion only.
// STRUCTURE
//  - Package display_pkg: state enum typedef (IDLE, SHIFT, FINISH), BCD digit typedef
//    logic [3:0], blank-digit constant, function computing NI from WIDTH.
//  - Sub-module bcd_add3: combinational 4-bit "add 3 if >=5" cell, generated NI times.
//  - Top holds FSM, shift counter, sign/magnitude registers, output formatting.
// TESTING
//  - VALUE=16'd1234, START 1 cycle -> DONE 17 cycles later; BCD=24'h001234, BLANK=6'b110000,
//    MINUS=0, ERR=0; BUSY high 17 cycles.
//  - VALUE=-45 -> BCD=24'h000045, BLANK=6'b111100, MINUS=6'b000100, ERR=0.
//  - VALUE=-32768 -> BCD=24'h032768, BLANK=6'b100000, MINUS=6'b100000; VALUE=0 -> BCD=0,
//    BLANK=6'b111110.
//  - WIDTH=24: VALUE=1000000 -> ERR=1, BLANK=all 1; VALUE=-100000 -> ERR=1; VALUE=-99999 -> ERR=0,
//    MINUS=6'b100000.
//  - START again at cycle 5 of a conversion -> ignored, single DONE, result of first VALUE;
//    RST_N low at cycle 8 -> no DONE, outputs at reset values, next START converts normally.
//  - HEX_MODE_EN, HEX_MODE=1, VALUE=16'hBEEF -> DONE next cycle, BCD=24'h00BEEF, BLANK=6'b110000.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and helpers for the BCD display formatter.
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_DIGIT = 4'h0;

    // Decimal digits needed to hold any WIDTH-bit magnitude.
    function automatic int calc_ni(input int w);
        return (w * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction cell, adds 3 to a digit that is 5 or more.
module bcd_add3
    import display_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_display_formatter.sv
// bcd_display_formatter: serial signed binary to BCD converter with blank/minus/overflow formatting.
// Optional HEX_MODE_EN adds i_hex_mode for raw hexadecimal display without conversion.
module bcd_display_formatter
    import display_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_value,
`ifdef HEX_MODE_EN
    input  logic                i_hex_mode,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic [DIGITS-1:0]   o_blank,
    output logic [DIGITS-1:0]   o_minus,
    output logic                o_err
);

    localparam int NI = calc_ni(WIDTH);
    localparam int CW = $clog2(WIDTH);

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic                    r_sign;
    logic [WIDTH-1:0]        r_mag;
    logic [4*NI-1:0]         r_bcd, w_adj, w_shifted, w_src;
    logic [4*(NI+DIGITS)-1:0] w_ext;
    logic                    w_hex, w_load, w_sign, w_err;
    logic [4*DIGITS-1:0]     w_bcd;
    logic [DIGITS-1:0]       w_blank, w_minus;
    int                      w_sig;
    logic [4*DIGITS-1:0]     r_obcd;
    logic [DIGITS-1:0]       r_blank, r_minus;
    logic                    r_err, r_done;

`ifdef HEX_MODE_EN
    assign w_hex = i_hex_mode;
`else
    assign w_hex = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_add3
            bcd_add3 u_add3 (.i_digit(r_bcd[4*g +: 4]), .o_digit(w_adj[4*g +: 4]));
        end
    endgenerate

    assign w_shifted = {w_adj[4*NI-2:0], r_mag[WIDTH-1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? (w_hex ? FINISH : SHIFT) : IDLE;
            SHIFT:   w_next = (r_cnt == '0) ? FINISH : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are captured on the edge entering FINISH so they are valid alongside DONE.
    assign w_load = (r_state == IDLE && i_start && w_hex) || (r_state == SHIFT && r_cnt == '0);
    assign w_src  = (r_state == IDLE) ? (4*NI)'(i_value) : w_shifted;
    assign w_sign = (r_state == IDLE) ? 1'b0 : r_sign;
    assign w_ext  = (4*(NI+DIGITS))'(w_src);

    always_comb begin
        w_sig   = 1;
        w_blank = '0;
        w_minus = '0;
        for (int i = 0; i < NI; i++)
            if (w_src[4*i +: 4] != 4'h0) w_sig = i + 1;
        w_err = (w_sig > DIGITS) || (w_sign && w_sig > DIGITS - 1);
        for (int i = 0; i < DIGITS; i++) begin
            w_blank[i] = w_err || (i != 0 && i >= w_sig);
            w_minus[i] = !w_err && w_sign && i == w_sig;
        end
        w_bcd = w_err ? {DIGITS{BLANK_DIGIT}} : w_ext[4*DIGITS-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_sign <= i_value[WIDTH-1];
                r_mag  <= i_value[WIDTH-1] ? -i_value : i_value;
                r_bcd  <= {NI{BLANK_DIGIT}};
                r_cnt  <= CW'(WIDTH - 1);
            end else if (r_state == SHIFT) begin
                r_bcd <= w_shifted;
                r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_obcd  <= '0;
            r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
            r_minus <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_obcd  <= w_bcd;
                r_blank <= w_blank;
                r_minus <= w_minus;
                r_err   <= w_err;
            end
        end
    end

    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_bcd   = r_obcd;
    assign o_blank = r_blank;
    assign o_minus = r_minus;
    assign o_err   = r_err;

endmodule
